// File: rtl/bridge_gearbox_if.sv
// rtl/bridge_gearbox_if.sv - beat handshake bundle for the lane-width gearbox
// Input side : vld_i, din[DIN_W][DATA_W], din_cnt, last_i -> rdy_o
// Output side: vld_o, dout[DOUT_W][DATA_W], dout_cnt, last_o <- rdy_i
// slave is the gearbox view, master is the producer/consumer view.
interface bridge_gearbox_if #(
  parameter int DIN_W  = 3,
  parameter int DOUT_W = 8,
  parameter int DATA_W = 8
);
  localparam int DCW = $clog2(DIN_W + 1);
  localparam int OCW = $clog2(DOUT_W + 1);

  logic                          vld_i;
  logic [DIN_W-1:0][DATA_W-1:0]  din;
  logic [DCW-1:0]                din_cnt;
  logic                          last_i;
  logic                          rdy_o;
  logic                          vld_o;
  logic [DOUT_W-1:0][DATA_W-1:0] dout;
  logic [OCW-1:0]                dout_cnt;
  logic                          last_o;
  logic                          rdy_i;

  modport slave (
    input  vld_i, din, din_cnt, last_i, rdy_i,
    output rdy_o, vld_o, dout, dout_cnt, last_o
  );

  modport master (
    output vld_i, din, din_cnt, last_i, rdy_i,
    input  rdy_o, vld_o, dout, dout_cnt, last_o
  );
endinterface

// File: rtl/bridge_gearbox.sv
// rtl/bridge_gearbox.sv - DIN_W-lane to DOUT_W-lane gearbox with per-beat lane counts
// Packs input lanes oldest-first into a REG_W-lane buffer and presents the
// lowest DOUT_W lanes as the output beat; last flushes a trailing partial beat.
// Ports: clk, a_rst_n (async, active-low), bus (bridge_gearbox_if.slave).
module bridge_gearbox #(
  parameter int DIN_W  = 3,
  parameter int DOUT_W = 8,
  parameter int DATA_W = 8,
  parameter int REG_W  = DIN_W + 2 * DOUT_W,
  parameter int CNT_W  = $clog2(REG_W + 1)
) (
  input  logic            clk,
  input  logic            a_rst_n,
  bridge_gearbox_if.slave bus
);
  localparam int DCW = $clog2(DIN_W + 1);
  localparam int OCW = $clog2(DOUT_W + 1);
  localparam int BW  = REG_W * DATA_W;

  logic [BW-1:0]    buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q;

  logic [DCW-1:0]   din_n;
  logic [BW-1:0]    din_wide;
  logic [OCW-1:0]   out_n;
  logic             out_last;
  logic             push, pop;
  logic [CNT_W-1:0] push_n, pop_n;

  assign din_n = (bus.din_cnt > DCW'(DIN_W)) ? DCW'(DIN_W) : bus.din_cnt;

  // Outputs depend on registered state only, so rdy_o has no path from rdy_i/vld_i.
  assign out_n    = (int'(cnt_q) >= DOUT_W) ? OCW'(DOUT_W) : OCW'(cnt_q);
  assign out_last = last_q && (int'(cnt_q) <= DOUT_W);

  assign bus.rdy_o    = !last_q && (int'(cnt_q) + DIN_W <= REG_W);
  assign bus.vld_o    = (int'(cnt_q) >= DOUT_W) || last_q;
  assign bus.dout     = buf_q[DOUT_W*DATA_W-1:0];
  assign bus.dout_cnt = out_n;
  assign bus.last_o   = out_last;

  assign push   = bus.vld_i && bus.rdy_o;
  assign pop    = bus.vld_o && bus.rdy_i;
  assign push_n = push ? CNT_W'(din_n) : '0;
  assign pop_n  = pop ? CNT_W'(out_n) : '0;

  // Unused lanes are zeroed so the buffer keeps zeros above cnt_q.
  always_comb begin
    din_wide = '0;
    for (int i = 0; i < DIN_W; i++) begin
      if (push && (i < int'(din_n))) din_wide[i*DATA_W +: DATA_W] = bus.din[i];
    end
  end

  // Popped lanes fall off the bottom; new lanes land right above what remains.
  always_comb begin
    cnt_d = cnt_q - pop_n + push_n;
    buf_d = (buf_q >> (int'(pop_n) * DATA_W)) |
            (din_wide << (int'(cnt_q - pop_n) * DATA_W));
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      buf_q  <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      // Set and clear never coincide: rdy_o is low while last_q is held.
      if (push && bus.last_i)    last_q <= 1'b1;
      else if (pop && out_last)  last_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bridge_gearbox.sv
// tb/tb_bridge_gearbox.sv - bench for bridge_gearbox, upsize 3->8 and downsize 8->3
module tb_bridge_gearbox;
  localparam int UI = 3, UO = 8, UR = UI + 2 * UO;
  localparam int DI = 8, DO = 3, DR = DI + 2 * DO;

  typedef struct packed {
    logic            last;
    logic [3:0]      n;
    logic [7:0][7:0] lanes;
  } beat_t;

  logic clk = 1'b0;
  logic a_rst_n = 1'b0;
  always #5 clk = ~clk;

  bridge_gearbox_if #(.DIN_W(UI), .DOUT_W(UO), .DATA_W(8)) up_if ();
  bridge_gearbox_if #(.DIN_W(DI), .DOUT_W(DO), .DATA_W(8)) dn_if ();

  bridge_gearbox #(.DIN_W(UI), .DOUT_W(UO), .DATA_W(8)) u_up (
    .clk(clk), .a_rst_n(a_rst_n), .bus(up_if.slave));
  bridge_gearbox #(.DIN_W(DI), .DOUT_W(DO), .DATA_W(8)) u_dn (
    .clk(clk), .a_rst_n(a_rst_n), .bus(dn_if.slave));

  int errors = 0;
  int checks = 0;

  // Reference model: lanes in flight as a plain FIFO plus a pending-last flag.
  beat_t      up_stim[$], up_got[$], dn_stim[$], dn_got[$];
  logic [7:0] up_mq[$], dn_mq[$], up_sent[$], up_recv[$], dn_sent[$], dn_recv[$];
  bit         up_ml, dn_ml;
  int         up_val, dn_val;

  task automatic up_add(input int n, input bit last);
    beat_t b;
    b.lanes = {$urandom, $urandom};
    for (int i = 0; i < n; i++) begin b.lanes[i] = 8'(up_val); up_val++; end
    b.n = 4'(n); b.last = last;
    up_stim.push_back(b);
  endtask

  task automatic dn_add(input int n, input bit last);
    beat_t b;
    b.lanes = {$urandom, $urandom};
    for (int i = 0; i < n; i++) begin b.lanes[i] = 8'(dn_val); dn_val++; end
    b.n = 4'(n); b.last = last;
    dn_stim.push_back(b);
  endtask

  task automatic up_run(input int vprob, input int rprob, input bit drain, input int budget);
    beat_t b, g;
    logic [UO-1:0][7:0] exp_d;
    int en;
    bit ev, er, el, done, push, pop;
    for (int cyc = 0; cyc <= budget; cyc++) begin
      @(negedge clk);
      en = (up_mq.size() < UO) ? up_mq.size() : UO;
      ev = (up_mq.size() >= UO) || up_ml;
      er = !up_ml && (up_mq.size() + UI <= UR);
      el = up_ml && (up_mq.size() <= UO);
      exp_d = '0;
      for (int i = 0; i < en; i++) exp_d[i] = up_mq[i];
      checks++; if (up_if.rdy_o !== er) begin errors++; $display("FAIL up_rdy_o t=%0t: got %b want %b", $time, up_if.rdy_o, er); end
      checks++; if (up_if.vld_o !== ev) begin errors++; $display("FAIL up_vld_o t=%0t: got %b want %b", $time, up_if.vld_o, ev); end
      checks++; if (up_if.dout_cnt !== 4'(en)) begin errors++; $display("FAIL up_dout_cnt t=%0t: got %0d want %0d", $time, up_if.dout_cnt, en); end
      checks++; if (up_if.last_o !== el) begin errors++; $display("FAIL up_last_o t=%0t: got %b want %b", $time, up_if.last_o, el); end
      checks++; if (up_if.dout !== exp_d) begin errors++; $display("FAIL up_dout t=%0t: got %h want %h", $time, up_if.dout, exp_d); end
      done = drain ? (up_stim.size() == 0 && up_mq.size() == 0 && !up_ml) : (up_stim.size() == 0);
      if (done || cyc == budget) begin
        up_if.vld_i = 1'b0; up_if.rdy_i = 1'b0;
        if (!done) begin checks++; errors++; $display("FAIL up_timeout: got busy want idle within %0d cycles", budget); end
        return;
      end
      up_if.vld_i = (up_stim.size() > 0) && ($urandom_range(99) < vprob);
      up_if.rdy_i = ($urandom_range(99) < rprob);
      b = (up_stim.size() > 0) ? up_stim[0] : '0;
      up_if.din = b.lanes[UI-1:0]; up_if.din_cnt = 2'(b.n); up_if.last_i = b.last;
      push = up_if.vld_i && er;
      pop  = ev && up_if.rdy_i;
      if (pop) begin
        g = '0; g.lanes[UO-1:0] = up_if.dout; g.n = up_if.dout_cnt; g.last = up_if.last_o;
        up_got.push_back(g);
        for (int i = 0; i < int'(g.n) && i < UO; i++) up_recv.push_back(g.lanes[i]);
        for (int i = 0; i < en; i++) void'(up_mq.pop_front());
        if (el) up_ml = 1'b0;
      end
      if (push) begin
        void'(up_stim.pop_front());
        for (int i = 0; i < int'(b.n); i++) begin up_mq.push_back(b.lanes[i]); up_sent.push_back(b.lanes[i]); end
        if (b.last) up_ml = 1'b1;
      end
    end
  endtask

  task automatic dn_run(input int vprob, input int rprob, input int budget);
    beat_t b, g;
    logic [DO-1:0][7:0] exp_d;
    int en;
    bit ev, er, el, done, push, pop;
    for (int cyc = 0; cyc <= budget; cyc++) begin
      @(negedge clk);
      en = (dn_mq.size() < DO) ? dn_mq.size() : DO;
      ev = (dn_mq.size() >= DO) || dn_ml;
      er = !dn_ml && (dn_mq.size() + DI <= DR);
      el = dn_ml && (dn_mq.size() <= DO);
      exp_d = '0;
      for (int i = 0; i < en; i++) exp_d[i] = dn_mq[i];
      checks++; if (dn_if.rdy_o !== er) begin errors++; $display("FAIL dn_rdy_o t=%0t: got %b want %b", $time, dn_if.rdy_o, er); end
      checks++; if (dn_if.vld_o !== ev) begin errors++; $display("FAIL dn_vld_o t=%0t: got %b want %b", $time, dn_if.vld_o, ev); end
      checks++; if (dn_if.dout_cnt !== 2'(en)) begin errors++; $display("FAIL dn_dout_cnt t=%0t: got %0d want %0d", $time, dn_if.dout_cnt, en); end
      checks++; if (dn_if.last_o !== el) begin errors++; $display("FAIL dn_last_o t=%0t: got %b want %b", $time, dn_if.last_o, el); end
      checks++; if (dn_if.dout !== exp_d) begin errors++; $display("FAIL dn_dout t=%0t: got %h want %h", $time, dn_if.dout, exp_d); end
      done = (dn_stim.size() == 0 && dn_mq.size() == 0 && !dn_ml);
      if (done || cyc == budget) begin
        dn_if.vld_i = 1'b0; dn_if.rdy_i = 1'b0;
        if (!done) begin checks++; errors++; $display("FAIL dn_timeout: got busy want idle within %0d cycles", budget); end
        return;
      end
      dn_if.vld_i = (dn_stim.size() > 0) && ($urandom_range(99) < vprob);
      dn_if.rdy_i = ($urandom_range(99) < rprob);
      b = (dn_stim.size() > 0) ? dn_stim[0] : '0;
      dn_if.din = b.lanes; dn_if.din_cnt = b.n; dn_if.last_i = b.last;
      push = dn_if.vld_i && er;
      pop  = ev && dn_if.rdy_i;
      if (pop) begin
        g = '0; g.lanes[DO-1:0] = dn_if.dout; g.n = 4'(dn_if.dout_cnt); g.last = dn_if.last_o;
        dn_got.push_back(g);
        for (int i = 0; i < int'(g.n) && i < DO; i++) dn_recv.push_back(g.lanes[i]);
        for (int i = 0; i < en; i++) void'(dn_mq.pop_front());
        if (el) dn_ml = 1'b0;
      end
      if (push) begin
        void'(dn_stim.pop_front());
        for (int i = 0; i < int'(b.n); i++) begin dn_mq.push_back(b.lanes[i]); dn_sent.push_back(b.lanes[i]); end
        if (b.last) dn_ml = 1'b1;
      end
    end
  endtask

  // Compares recorded up-side beats against n lanes starting at v0, split every UO.
  task automatic up_expect(input string name, input int total, input int v0);
    beat_t e;
    int nb;
    nb = (total + UO - 1) / UO;
    if (nb == 0) nb = 1;
    checks++;
    if (up_got.size() != nb) begin errors++; $display("FAIL %s_beats: got %0d want %0d", name, up_got.size(), nb); end
    for (int k = 0; k < nb && k < up_got.size(); k++) begin
      e = '0;
      e.n = 4'(((total - k * UO) > UO) ? UO : (total - k * UO));
      e.last = (k == nb - 1);
      for (int i = 0; i < int'(e.n); i++) e.lanes[i] = 8'(v0 + k * UO + i);
      checks++;
      if (up_got[k] !== e) begin errors++; $display("FAIL %s_beat%0d: got %h want %h", name, k, up_got[k], e); end
    end
  endtask

  task automatic test_reset;
    up_if.vld_i = 0; up_if.rdy_i = 0; up_if.din = '0; up_if.din_cnt = '0; up_if.last_i = 0;
    dn_if.vld_i = 0; dn_if.rdy_i = 0; dn_if.din = '0; dn_if.din_cnt = '0; dn_if.last_i = 0;
    a_rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (up_if.vld_o !== 1'b0) begin errors++; $display("FAIL rst_up_vld_o: got %b want 0", up_if.vld_o); end
    checks++; if (up_if.rdy_o !== 1'b1) begin errors++; $display("FAIL rst_up_rdy_o: got %b want 1", up_if.rdy_o); end
    checks++; if (up_if.dout_cnt !== 4'd0) begin errors++; $display("FAIL rst_up_dout_cnt: got %0d want 0", up_if.dout_cnt); end
    checks++; if (up_if.last_o !== 1'b0) begin errors++; $display("FAIL rst_up_last_o: got %b want 0", up_if.last_o); end
    checks++; if (up_if.dout !== '0) begin errors++; $display("FAIL rst_up_dout: got %h want 0", up_if.dout); end
    checks++;
    if ({dn_if.vld_o, dn_if.rdy_o, dn_if.dout_cnt, dn_if.last_o, dn_if.dout} !== {1'b0, 1'b1, 2'd0, 1'b0, 24'd0}) begin
      errors++; $display("FAIL rst_dn_outputs: got vld=%b rdy=%b cnt=%0d last=%b dout=%h want 0 1 0 0 0",
                         dn_if.vld_o, dn_if.rdy_o, dn_if.dout_cnt, dn_if.last_o, dn_if.dout);
    end
    up_mq.delete(); dn_mq.delete(); up_ml = 0; dn_ml = 0;
    a_rst_n = 1'b1;
  endtask

  task automatic test_upsize_full;
    up_got.delete(); up_val = 0;
    for (int k = 0; k < 8; k++) up_add(3, k == 7);
    up_run(100, 100, 1, 200);
    up_expect("upsize_full", 24, 0);
  endtask

  task automatic test_upsize_partial;
    up_got.delete(); up_val = 0;
    for (int k = 0; k < 7; k++) up_add(3, k == 6);
    up_run(100, 100, 1, 200);
    up_expect("upsize_partial", 21, 0);
  endtask

  task automatic test_zero_len;
    up_got.delete(); up_val = 50;
    up_add(0, 1);
    up_run(100, 100, 1, 50);
    up_expect("zero_len", 0, 50);
  endtask

  task automatic test_downsize;
    int want_n[6] = '{3, 3, 3, 3, 3, 1};
    dn_got.delete(); dn_val = 100;
    dn_add(8, 0); dn_add(8, 1);
    dn_run(100, 100, 100);
    checks++;
    if (dn_got.size() != 6) begin errors++; $display("FAIL downsize_beats: got %0d want 6", dn_got.size()); end
    for (int k = 0; k < 6 && k < dn_got.size(); k++) begin
      checks++;
      if (dn_got[k].n != 4'(want_n[k]) || dn_got[k].last != (k == 5) || dn_got[k].lanes[0] != 8'(100 + 3 * k)) begin
        errors++; $display("FAIL downsize_beat%0d: got n=%0d last=%b lane0=%0d want n=%0d last=%b lane0=%0d",
                           k, dn_got[k].n, dn_got[k].last, dn_got[k].lanes[0], want_n[k], k == 5, 100 + 3 * k);
      end
    end
  endtask

  task automatic test_random;
    int nb, npk, nlast, bad;
    up_sent.delete(); up_recv.delete(); up_got.delete();
    dn_sent.delete(); dn_recv.delete(); dn_got.delete();
    npk = 0;
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 6; p++) begin
        nb = $urandom_range(1, 6);
        for (int k = 0; k < nb; k++) up_add($urandom_range(0, UI), k == nb - 1);
        nb = $urandom_range(1, 4);
        for (int k = 0; k < nb; k++) dn_add($urandom_range(0, DI), k == nb - 1);
        npk++;
      end
      fork
        up_run($urandom_range(40, 100), $urandom_range(30, 100), 1, 3000);
        dn_run($urandom_range(40, 100), $urandom_range(30, 100), 3000);
      join
    end
    nlast = 0;
    foreach (up_got[k]) if (up_got[k].last) nlast++;
    checks++; if (nlast != npk) begin errors++; $display("FAIL rand_up_packets: got %0d want %0d", nlast, npk); end
    nlast = 0;
    foreach (dn_got[k]) if (dn_got[k].last) nlast++;
    checks++; if (nlast != npk) begin errors++; $display("FAIL rand_dn_packets: got %0d want %0d", nlast, npk); end
    bad = (up_recv.size() != up_sent.size()) ? 1 : 0;
    for (int i = 0; i < up_recv.size() && i < up_sent.size(); i++) if (up_recv[i] !== up_sent[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rand_up_lanes: got %0d lanes (%0d bad) want %0d", up_recv.size(), bad, up_sent.size()); end
    bad = (dn_recv.size() != dn_sent.size()) ? 1 : 0;
    for (int i = 0; i < dn_recv.size() && i < dn_sent.size(); i++) if (dn_recv[i] !== dn_sent[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL rand_dn_lanes: got %0d lanes (%0d bad) want %0d", dn_recv.size(), bad, dn_sent.size()); end
  endtask

  task automatic test_reset_mid;
    up_got.delete(); up_val = 200;
    up_add(3, 0); up_add(2, 0);
    up_run(100, 100, 0, 50);
    #2 a_rst_n = 1'b0;
    #1;
    checks++; if (up_if.vld_o !== 1'b0) begin errors++; $display("FAIL midrst_vld_o: got %b want 0", up_if.vld_o); end
    checks++; if (up_if.rdy_o !== 1'b1) begin errors++; $display("FAIL midrst_rdy_o: got %b want 1", up_if.rdy_o); end
    checks++; if (up_if.dout_cnt !== 4'd0 || up_if.dout !== '0) begin errors++; $display("FAIL midrst_dout: got cnt=%0d dout=%h want 0 0", up_if.dout_cnt, up_if.dout); end
    up_mq.delete(); up_ml = 0;
    #1 a_rst_n = 1'b1;
    up_add(3, 0); up_add(3, 0); up_add(2, 1);
    up_run(100, 100, 1, 100);
    up_expect("midrst_new", 8, 205);
  endtask

  initial begin
    test_reset();
    test_upsize_full();
    test_upsize_partial();
    test_zero_len();
    test_downsize();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
